// File: rtl/alu_sched_if.sv
// alu_sched_if: bundles every handshake and bus signal that surrounds the ALU
// scheduler. The two requester channels (req/rsp pairs) and the ALU pin group
// all sit here.
//
// Modports:
//   slave  - the scheduler side (alu_sched).
//   master - the environment side: the requesters plus the combinational ALU.
//
// Handshake rule for every valid/ready pair in this interface: a transfer
// happens on a rising clock edge where valid and ready are both sampled high.
// The valid side keeps its payload stable while valid is high and the
// transfer has not happened yet. A requester may drop req*_valid before
// acceptance without penalty.
interface alu_sched_if;
  // requester 0
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [31:0] rsp0_result;
  logic        rsp0_zero;
  // requester 1
  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp1_result;
  logic        rsp1_zero;
  // ALU pins
  logic [3:0]  alu_operation;
  logic [31:0] alu_data_a;
  logic [31:0] alu_data_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  // status
  logic        busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    input  alu_result, alu_zero,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_zero,
    output alu_operation, alu_data_a, alu_data_b, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    output alu_result, alu_zero,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_zero,
    input  alu_operation, alu_data_a, alu_data_b, busy
  );
endinterface

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler that shares one combinational 32-bit ALU
// between two requesters. It accepts one operation at a time and registers
// the operation and operands onto the ALU pins. It waits one cycle for the
// ALU to settle, captures result/zero, and then returns them to the owning
// requester with a valid/ready handshake.
//
// Ports:
//   clk       - sole clock, rising edge
//   rst_n     - asynchronous active-low reset
//   bus       - alu_sched_if.slave: req0/req1, rsp0/rsp1, ALU pins, busy
//   state_dbg - current FSM state (0 IDLE, 1 EXEC, 2 RESP)
module alu_sched (
  input  logic        clk,
  input  logic        rst_n,
  alu_sched_if.slave  bus,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic        owner;
  logic        last_grant;
  logic        grant;
  logic        grant_valid;
  logic        rsp_done;

  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] result_q;
  logic        zero_q;
  logic        rsp0_valid_q;
  logic        rsp1_valid_q;
  logic        busy_q;

  // Round-robin grant. When both requesters are valid, the one that did not
  // win last time gets the grant.
  always_comb begin
    grant_valid = bus.req0_valid | bus.req1_valid;
    grant       = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  // Ready is gated by rst_n so no requester sees ready while reset is held.
  assign bus.req0_ready = rst_n && (state == IDLE) && grant_valid && (grant == 1'b0);
  assign bus.req1_ready = rst_n && (state == IDLE) && grant_valid && (grant == 1'b1);

  // Only the owner's rsp_ready can complete a response.
  assign rsp_done = owner ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      op_q         <= 4'b0000;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      result_q     <= 32'd0;
      zero_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            // Operation and operands are owned from here on; requester
            // inputs are ignored until the next grant.
            op_q       <= grant ? bus.req1_op : bus.req0_op;
            a_q        <= grant ? bus.req1_a  : bus.req0_a;
            b_q        <= grant ? bus.req1_b  : bus.req0_b;
            owner      <= grant;
            last_grant <= grant;
            busy_q     <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          result_q     <= bus.alu_result;
          zero_q       <= bus.alu_zero;
          rsp0_valid_q <= (owner == 1'b0);
          rsp1_valid_q <= (owner == 1'b1);
          state        <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  // One captured result register serves both response ports; only the
  // owner's valid is ever raised.
  assign bus.rsp0_valid    = rsp0_valid_q;
  assign bus.rsp1_valid    = rsp1_valid_q;
  assign bus.rsp0_result   = result_q;
  assign bus.rsp1_result   = result_q;
  assign bus.rsp0_zero     = zero_q;
  assign bus.rsp1_zero     = zero_q;
  assign bus.alu_operation = op_q;
  assign bus.alu_data_a    = a_q;
  assign bus.alu_data_b    = b_q;
  assign bus.busy          = busy_q;
  assign state_dbg         = state;

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed bench for alu_sched. A small combinational ALU
// model sits on the ALU pins. Outputs are sampled on the falling clock edge
// and inputs are driven there as well.
module tb_alu_sched;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  alu_sched_if bus ();

  alu_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- external ALU model ----------------
  logic [31:0] alu_res;
  always_comb begin
    alu_res = bus.alu_data_a + bus.alu_data_b;
    case (bus.alu_operation)
      4'b0000: alu_res = bus.alu_data_a & bus.alu_data_b;
      4'b0001: alu_res = bus.alu_data_a | bus.alu_data_b;
      4'b0010: alu_res = bus.alu_data_a + bus.alu_data_b;
      4'b0110: alu_res = bus.alu_data_a - bus.alu_data_b;
      4'b0111: alu_res = ($signed(bus.alu_data_a) < $signed(bus.alu_data_b)) ? 32'd1 : 32'd0;
      4'b1100: alu_res = ~(bus.alu_data_a | bus.alu_data_b);
      default: alu_res = bus.alu_data_a + bus.alu_data_b;
    endcase
  end
  assign bus.alu_result = alu_res;
  assign bus.alu_zero   = (alu_res == 32'd0);

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [31:0] act);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s actual=%h expected=<empty queue>", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        failures++;
        $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_req(input logic id, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    if (id == 1'b0) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  // Drop valid and scramble the payload; the scheduler must ignore it.
  task automatic drop_req(input logic id);
    if (id == 1'b0) begin
      bus.req0_valid = 1'b0; bus.req0_op = 4'($urandom_range(0, 15));
      bus.req0_a = $urandom; bus.req0_b = $urandom;
    end else begin
      bus.req1_valid = 1'b0; bus.req1_op = 4'($urandom_range(0, 15));
      bus.req1_a = $urandom; bus.req1_b = $urandom;
    end
  endtask

  function automatic logic ready_of(input logic id);
    return id ? bus.req1_ready : bus.req0_ready;
  endfunction

  function automatic logic rsp_valid_of(input logic id);
    return id ? bus.rsp1_valid : bus.rsp0_valid;
  endfunction

  function automatic logic [31:0] rsp_result_of(input logic id);
    return id ? bus.rsp1_result : bus.rsp0_result;
  endfunction

  function automatic logic rsp_zero_of(input logic id);
    return id ? bus.rsp1_zero : bus.rsp0_zero;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[9];

  // Full single transaction with rsp_ready high, checking exact latency:
  // accept edge, EXEC, RESP on the next edge, complete on the one after.
  task automatic run_txn(input vec_t v, input int idx);
    drive_req(v.id, v.op, v.a, v.b);
    #1;
    check($sformatf("v%0d ready", idx), {31'd0, ready_of(v.id)}, 32'd1);
    check($sformatf("v%0d other_ready", idx), {31'd0, ready_of(~v.id)}, 32'd0);
    exp_q.push_back(v.exp_res);
    tick();
    drop_req(v.id);
    #1;
    check($sformatf("v%0d exec_busy", idx), {31'd0, bus.busy}, 32'd1);
    check($sformatf("v%0d exec_op", idx), {28'd0, bus.alu_operation}, {28'd0, v.op});
    check($sformatf("v%0d exec_a", idx), bus.alu_data_a, v.a);
    check($sformatf("v%0d exec_b", idx), bus.alu_data_b, v.b);
    check($sformatf("v%0d exec_no_rsp", idx), {31'd0, rsp_valid_of(v.id)}, 32'd0);
    tick();
    check($sformatf("v%0d rsp_valid", idx), {31'd0, rsp_valid_of(v.id)}, 32'd1);
    check($sformatf("v%0d other_rsp_valid", idx), {31'd0, rsp_valid_of(~v.id)}, 32'd0);
    sb_check($sformatf("v%0d result", idx), rsp_result_of(v.id));
    check($sformatf("v%0d zero", idx), {31'd0, rsp_zero_of(v.id)}, {31'd0, v.exp_zero});
    tick();
    check($sformatf("v%0d done_valid", idx), {31'd0, rsp_valid_of(v.id)}, 32'd0);
    check($sformatf("v%0d done_busy", idx), {31'd0, bus.busy}, 32'd0);
  endtask

  // Both requesters valid: req0 sub 3-3 (0, zero 1), req1 slt -1<1 (1, zero 0).
  // 'first' is the requester expected to win the arbitration.
  task automatic contention(input logic first, input string tag);
    logic [31:0] exp_r0 = 32'd0;
    logic [31:0] exp_r1 = 32'd1;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    drive_req(1'b0, 4'b0110, 32'd3, 32'd3);
    drive_req(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd1);
    #1;
    check({tag, " first_ready"}, {31'd0, ready_of(first)}, 32'd1);
    check({tag, " second_not_ready"}, {31'd0, ready_of(~first)}, 32'd0);
    exp_q.push_back(first ? exp_r1 : exp_r0);
    tick();
    drop_req(first);
    #1;
    check({tag, " second_blocked"}, {31'd0, ready_of(~first)}, 32'd0);
    tick();
    check({tag, " first_rsp_valid"}, {31'd0, rsp_valid_of(first)}, 32'd1);
    sb_check({tag, " first_result"}, rsp_result_of(first));
    check({tag, " first_zero"}, {31'd0, rsp_zero_of(first)}, first ? 32'd0 : 32'd1);
    tick();
    check({tag, " second_ready"}, {31'd0, ready_of(~first)}, 32'd1);
    exp_q.push_back(first ? exp_r0 : exp_r1);
    tick();
    drop_req(~first);
    tick();
    check({tag, " second_rsp_valid"}, {31'd0, rsp_valid_of(~first)}, 32'd1);
    sb_check({tag, " second_result"}, rsp_result_of(~first));
    check({tag, " second_zero"}, {31'd0, rsp_zero_of(~first)}, first ? 32'd1 : 32'd0);
    tick();
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{1'b0, 4'b0010, 32'd5,          32'd7,          32'd12,         1'b0};
    vecs[1] = '{1'b0, 4'b1100, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0};
    vecs[2] = '{1'b1, 4'b0000, 32'hF0F0_F0F0,  32'h0F0F_0F0F,  32'd0,          1'b1};
    vecs[3] = '{1'b0, 4'b1111, 32'd2,          32'd3,          32'd5,          1'b0};
    vecs[4] = '{1'b1, 4'b0001, 32'hF0F0_F0F0,  32'h0F0F_0F0F,  32'hFFFF_FFFF,  1'b0};
    vecs[5] = '{1'b0, 4'b0110, 32'd10,         32'd3,          32'd7,          1'b0};
    vecs[6] = '{1'b1, 4'b0111, 32'hFFFF_FFFE,  32'd1,          32'd1,          1'b0};
    vecs[7] = '{1'b1, 4'b0111, 32'd5,          32'hFFFF_FFFB,  32'd0,          1'b1};
    vecs[8] = '{1'b1, 4'b0010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};

    // Reset held with both valids high.
    rst_n = 1'b0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    drive_req(1'b0, 4'b0010, 32'd1, 32'd1);
    drive_req(1'b1, 4'b0010, 32'd2, 32'd2);
    repeat (3) tick();
    check("rst req0_ready", {31'd0, bus.req0_ready}, 32'd0);
    check("rst req1_ready", {31'd0, bus.req1_ready}, 32'd0);
    check("rst rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
    check("rst rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
    check("rst rsp0_result", bus.rsp0_result, 32'd0);
    check("rst rsp1_zero", {31'd0, bus.rsp1_zero}, 32'd0);
    check("rst alu_op", {28'd0, bus.alu_operation}, 32'd0);
    check("rst alu_a", bus.alu_data_a, 32'd0);
    check("rst alu_b", bus.alu_data_b, 32'd0);
    check("rst busy", {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel req0_ready", {31'd0, bus.req0_ready}, 32'd1);
    check("rel req1_ready", {31'd0, bus.req1_ready}, 32'd0);
    drop_req(1'b0);
    drop_req(1'b1);
    tick();
    check("idle busy", {31'd0, bus.busy}, 32'd0);

    // Directed table.
    for (int i = 0; i < 9; i++) run_txn(vecs[i], i);

    // Contention: last served was req1, so req0 wins first.
    contention(1'b0, "cont1");
    // A single req0 transaction leaves last_grant=0, so req1 then wins.
    run_txn('{1'b0, 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0}, 100);
    contention(1'b1, "cont2");

    // Backpressure: last_grant=0, so req1 wins; rsp1_ready low for 5 cycles.
    // rsp0_ready stays high and must be ignored while req1 owns the response.
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b0;
    drive_req(1'b1, 4'b0010, 32'd100, 32'd23);
    drive_req(1'b0, 4'b0010, 32'd1, 32'd2);
    #1;
    check("bp req1_ready", {31'd0, bus.req1_ready}, 32'd1);
    exp_q.push_back(32'd123);
    tick();
    drop_req(1'b1);
    tick();
    sb_check("bp result", bus.rsp1_result);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp c%0d rsp1_valid", c), {31'd0, bus.rsp1_valid}, 32'd1);
      check($sformatf("bp c%0d rsp1_result", c), bus.rsp1_result, 32'd123);
      check($sformatf("bp c%0d rsp0_valid", c), {31'd0, bus.rsp0_valid}, 32'd0);
      check($sformatf("bp c%0d req0_ready", c), {31'd0, bus.req0_ready}, 32'd0);
      tick();
    end
    bus.rsp1_ready = 1'b1;
    #1;
    check("bp no_bypass", {31'd0, bus.req0_ready}, 32'd0);
    tick();
    check("bp rsp1_done", {31'd0, bus.rsp1_valid}, 32'd0);
    check("bp req0_ready_after", {31'd0, bus.req0_ready}, 32'd1);
    exp_q.push_back(32'd3);
    tick();
    drop_req(1'b0);
    tick();
    check("bp req0_rsp_valid", {31'd0, bus.rsp0_valid}, 32'd1);
    sb_check("bp req0_result", bus.rsp0_result);
    tick();

    // Reset during EXEC.
    drive_req(1'b0, 4'b0010, 32'd4, 32'd4);
    tick();
    drop_req(1'b0);
    #1;
    check("rexec busy_before", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rexec rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
    check("rexec busy", {31'd0, bus.busy}, 32'd0);
    check("rexec alu_a", bus.alu_data_a, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("rexec post%0d rsp0_valid", c), {31'd0, bus.rsp0_valid}, 32'd0);
      check($sformatf("rexec post%0d busy", c), {31'd0, bus.busy}, 32'd0);
    end

    // Reset during RESP.
    bus.rsp0_ready = 1'b0;
    drive_req(1'b0, 4'b0010, 32'd4, 32'd4);
    tick();
    drop_req(1'b0);
    tick();
    check("rresp rsp0_valid_before", {31'd0, bus.rsp0_valid}, 32'd1);
    check("rresp result_before", bus.rsp0_result, 32'd8);
    rst_n = 1'b0;
    #1;
    check("rresp rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
    check("rresp rsp0_result", bus.rsp0_result, 32'd0);
    check("rresp busy", {31'd0, bus.busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.rsp0_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("rresp post%0d rsp0_valid", c), {31'd0, bus.rsp0_valid}, 32'd0);
    end
    // After reset, req0 wins the first contention again.
    drive_req(1'b0, 4'b0010, 32'd1, 32'd1);
    drive_req(1'b1, 4'b0010, 32'd1, 32'd1);
    #1;
    check("rresp req0_wins", {31'd0, bus.req0_ready}, 32'd1);
    check("rresp req1_loses", {31'd0, bus.req1_ready}, 32'd0);
    drop_req(1'b0);
    drop_req(1'b1);
    tick();

    // ---------------- final report ----------------
    check("exp_q empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
